// File: rtl/flasher_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | flasher_pkg                                                                 |
// | Shared state encoding, compare-direction constants and rate helper for the  |
// | flash alert controller.                                                     |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
package flasher_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FL_ON  = 3'd1,
        FL_OFF = 3'd2,
        HOLD   = 3'd3,
        ACKED  = 3'd4
    } state_t;

    localparam logic CMP_GE = 1'b1;
    localparam logic CMP_LE = 1'b0;

    // A zero rate would never end a phase, so it is promoted to one tick.
    function automatic int unsigned rate_eff(input int unsigned rate);
        return (rate == 0) ? 32'd1 : rate;
    endfunction

endpackage
`default_nettype wire

// File: rtl/flash_cond_cmp.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | flash_cond_cmp                                                              |
// | Selects the active mode's threshold/direction and compares the time value. |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module flash_cond_cmp
    import flasher_pkg::*;
#(
    parameter  int DIGIT_W = 8,
    parameter  int MODES   = 2,
    localparam int MODE_W  = (MODES > 1) ? $clog2(MODES) : 1
) (
    input  logic [MODE_W-1:0]        i_mode_sel,
    input  logic [DIGIT_W-1:0]       i_msb,
    input  logic [DIGIT_W-1:0]       i_lsb,
    input  logic [MODES*2*DIGIT_W-1:0] i_threshold,
    input  logic [MODES-1:0]         i_dir,
    input  logic                     i_stopped,
    output logic                     o_cond
);

    localparam int TV_W = 2 * DIGIT_W;

    logic [TV_W-1:0] w_tv;
    logic [TV_W-1:0] w_thr;
    logic [31:0]     w_mode_ext;
    logic            w_mode_ok;
    logic            w_dir;

    always_comb begin
        w_tv       = {i_msb, i_lsb};
        // Widened so the range test stays meaningful when MODES is a power of two.
        w_mode_ext = 32'(i_mode_sel);
        w_mode_ok  = (w_mode_ext < 32'(MODES));
        w_thr      = '0;
        w_dir      = CMP_LE;
        for (int k = 0; k < MODES; k++) begin
            if (w_mode_ext == 32'(k)) begin
                w_thr = i_threshold[k*TV_W +: TV_W];
                w_dir = i_dir[k];
            end
        end
        o_cond = w_mode_ok & ~i_stopped &
                 ((w_dir == CMP_GE) ? (w_tv >= w_thr) : (w_tv <= w_thr));
    end

endmodule
`default_nettype wire

// File: rtl/flash_alert_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | flash_alert_ctrl                                                            |
// | Threshold-triggered blinking alert with programmable rate, flash limit and |
// | acknowledge. All outputs registered.                                        |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module flash_alert_ctrl
    import flasher_pkg::*;
#(
    parameter  int DIGIT_W = 8,
    parameter  int MODES   = 2,
    parameter  int RATE_W  = 3,
    parameter  int MAX_FL  = 5,
    parameter  int CNT_W   = 4,
    localparam int MODE_W  = (MODES > 1) ? $clog2(MODES) : 1
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       TICK,
    input  logic [MODE_W-1:0]          ModeSel,
    input  logic [DIGIT_W-1:0]         MSB,
    input  logic [DIGIT_W-1:0]         LSB,
    input  logic [MODES*2*DIGIT_W-1:0] Threshold,
    input  logic [MODES-1:0]           Dir,
    input  logic [RATE_W-1:0]          Rate,
    input  logic                       Stopped,
    input  logic                       Ack,
    output logic                       FlashingLED,
    output logic                       Active,
    output logic [CNT_W-1:0]           FlashCount
);

    localparam int              c_rw1     = RATE_W + 1;
    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    localparam logic [31:0]     c_max_fl  = 32'(MAX_FL);
    localparam bit              c_limited = (MAX_FL != 0);

    state_t             r_state, w_state_nxt;
    logic [RATE_W-1:0]  r_tick_cnt, w_tick_cnt_nxt;
    logic [CNT_W-1:0]   r_flash_cnt, w_flash_cnt_nxt;
    logic               r_led, r_active;
    logic               w_cond;
    logic [RATE_W:0]    w_tick_inc;
    logic [RATE_W:0]    w_rate_eff;
    logic               w_phase_end;

    flash_cond_cmp #(
        .DIGIT_W (DIGIT_W),
        .MODES   (MODES)
    ) u_cond (
        .i_mode_sel  (ModeSel),
        .i_msb       (MSB),
        .i_lsb       (LSB),
        .i_threshold (Threshold),
        .i_dir       (Dir),
        .i_stopped   (Stopped),
        .o_cond      (w_cond)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_tick_cnt_nxt  = r_tick_cnt;
        w_flash_cnt_nxt = r_flash_cnt;
        w_tick_inc      = {1'b0, r_tick_cnt} + c_rw1'(1);
        w_rate_eff      = c_rw1'(rate_eff(32'(Rate)));
        // ">=" lets a counter already past a newly lowered rate end the phase at once.
        w_phase_end     = (w_tick_inc >= w_rate_eff);

        case (r_state)
            IDLE: begin
                if (w_cond) begin
                    w_state_nxt     = FL_ON;
                    w_tick_cnt_nxt  = '0;
                    w_flash_cnt_nxt = '0;
                end
            end
            FL_ON, FL_OFF: begin
                if (!w_cond) begin
                    w_state_nxt = IDLE;
                end else if (Ack) begin
                    w_state_nxt = ACKED;
                end else if (TICK) begin
                    if (!w_phase_end) begin
                        w_tick_cnt_nxt = w_tick_inc[RATE_W-1:0];
                    end else begin
                        w_tick_cnt_nxt = '0;
                        if (r_state == FL_ON) begin
                            w_state_nxt = FL_OFF;
                            if (r_flash_cnt != c_cnt_max) begin
                                w_flash_cnt_nxt = r_flash_cnt + c_cnt_one;
                            end
                        end else if (c_limited && (32'(r_flash_cnt) >= c_max_fl)) begin
                            w_state_nxt = HOLD;
                        end else begin
                            w_state_nxt = FL_ON;
                        end
                    end
                end
            end
            HOLD: begin
                if (!w_cond) begin
                    w_state_nxt = IDLE;
                end else if (Ack) begin
                    w_state_nxt = ACKED;
                end
            end
            ACKED: begin
                if (!w_cond) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= IDLE;
            r_tick_cnt  <= '0;
            r_flash_cnt <= '0;
            r_led       <= 1'b0;
            r_active    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_tick_cnt  <= w_tick_cnt_nxt;
            r_flash_cnt <= w_flash_cnt_nxt;
            r_led       <= (w_state_nxt == FL_ON) || (w_state_nxt == HOLD);
            r_active    <= (w_state_nxt == FL_ON) || (w_state_nxt == FL_OFF) ||
                           (w_state_nxt == HOLD);
        end
    end

    assign FlashingLED = r_led;
    assign Active      = r_active;
    assign FlashCount  = r_flash_cnt;

endmodule
`default_nettype wire

// File: tb/tb_flash_alert_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_flash_alert_ctrl                                                         |
// | Directed bench with an episode-level reference model checked every cycle.  |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module tb_flash_alert_ctrl;

    localparam int MAX_FL = 5;

    logic        clk = 1'b0;
    logic        RST, TICK, ModeSel, Stopped, Ack;
    logic [1:0]  ModeSel3;
    logic [7:0]  MSB, LSB;
    logic [31:0] Threshold;
    logic [47:0] Threshold3;
    logic [1:0]  Dir;
    logic [2:0]  Dir3;
    logic [2:0]  Rate;
    logic        led0, act0, led3, act3;
    logic [3:0]  fc0, fc3;

    int  n_checks = 0;
    int  n_pass   = 0;
    bit  cmp_en   = 1'b0;

    bit  m_ep[2], m_ack[2], m_hold[2], m_on[2];
    int  m_ticks[2], m_cnt[2];

    always #5 clk = ~clk;

    flash_alert_ctrl #(.DIGIT_W(8), .MODES(2), .RATE_W(3), .MAX_FL(MAX_FL), .CNT_W(4)) u_dut (
        .CLK(clk), .RST(RST), .TICK(TICK), .ModeSel(ModeSel), .MSB(MSB), .LSB(LSB),
        .Threshold(Threshold), .Dir(Dir), .Rate(Rate), .Stopped(Stopped), .Ack(Ack),
        .FlashingLED(led0), .Active(act0), .FlashCount(fc0)
    );

    // Three-mode instance so an out-of-range ModeSel (3) is representable.
    flash_alert_ctrl #(.DIGIT_W(8), .MODES(3), .RATE_W(3), .MAX_FL(MAX_FL), .CNT_W(4)) u_dut3 (
        .CLK(clk), .RST(RST), .TICK(TICK), .ModeSel(ModeSel3), .MSB(MSB), .LSB(LSB),
        .Threshold(Threshold3), .Dir(Dir3), .Rate(Rate), .Stopped(Stopped), .Ack(Ack),
        .FlashingLED(led3), .Active(act3), .FlashCount(fc3)
    );

    function automatic bit mcond(input int modes, input int msel, input int tv,
                                 input logic [47:0] thr, input logic [2:0] dir, input logic stop);
        int t;
        if (msel >= modes || stop) return 1'b0;
        t = int'((thr >> (msel * 16)) & 48'hFFFF);
        return dir[msel] ? (tv >= t) : (tv <= t);
    endfunction

    task automatic model_step(input int d);
        bit c;
        int re;
        if (d == 0) c = mcond(2, int'(ModeSel), int'({MSB, LSB}), {16'h0, Threshold}, {1'b0, Dir}, Stopped);
        else        c = mcond(3, int'(ModeSel3), int'({MSB, LSB}), Threshold3, Dir3, Stopped);
        re = (Rate == 0) ? 1 : int'(Rate);
        if (RST) begin
            m_ep[d] = 0; m_ack[d] = 0; m_hold[d] = 0; m_on[d] = 0; m_ticks[d] = 0; m_cnt[d] = 0;
        end else if (!c) begin
            m_ep[d] = 0; m_ack[d] = 0;
        end else if (m_ack[d]) begin
            m_ack[d] = 1;
        end else if (!m_ep[d]) begin
            m_ep[d] = 1; m_on[d] = 1; m_hold[d] = 0; m_ticks[d] = 0; m_cnt[d] = 0;
        end else if (Ack) begin
            m_ep[d] = 0; m_ack[d] = 1;
        end else if (!m_hold[d] && TICK) begin
            m_ticks[d]++;
            if (m_ticks[d] >= re) begin
                m_ticks[d] = 0;
                if (m_on[d]) begin
                    m_on[d] = 0;
                    if (m_cnt[d] < 15) m_cnt[d]++;
                end else if (MAX_FL != 0 && m_cnt[d] >= MAX_FL) begin
                    m_hold[d] = 1;
                end else begin
                    m_on[d] = 1;
                end
            end
        end
    endtask

    function automatic int mled(input int d);
        return (m_ep[d] && (m_hold[d] || m_on[d])) ? 1 : 0;
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) model_step(d);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("led0_vs_model", int'(led0), mled(0));
            chk("act0_vs_model", int'(act0), int'(m_ep[0]));
            chk("fc0_vs_model",  int'(fc0),  m_cnt[0]);
            chk("led3_vs_model", int'(led3), mled(1));
            chk("act3_vs_model", int'(act3), int'(m_ep[1]));
            chk("fc3_vs_model",  int'(fc3),  m_cnt[1]);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick_once();
        TICK = 1'b1;
        cyc(1);
        TICK = 1'b0;
    endtask

    // Hand-computed expectations, applied to both the DUT and the model.
    task automatic lit(input int d, input string name, input int el, input int ea, input int ef);
        @(negedge clk);
        if (d == 0) begin
            chk({name, "_led"}, int'(led0), el);
            chk({name, "_act"}, int'(act0), ea);
            chk({name, "_fc"},  int'(fc0),  ef);
        end else begin
            chk({name, "_led"}, int'(led3), el);
            chk({name, "_act"}, int'(act3), ea);
            chk({name, "_fc"},  int'(fc3),  ef);
        end
        chk({name, "_model_led"}, mled(d), el);
        chk({name, "_model_fc"},  m_cnt[d], ef);
    endtask

    initial begin
        RST = 1'b1; TICK = 1'b0; ModeSel = 1'b0; ModeSel3 = 2'd3; Stopped = 1'b0; Ack = 1'b0;
        MSB = 8'd1; LSB = 8'd49; Rate = 3'd1; Dir = 2'b01; Dir3 = 3'b101;
        Threshold  = {16'h0131, 16'h5A00};
        Threshold3 = {16'h0000, 16'h0131, 16'h5A00};
        cyc(3);
        lit(0, "reset", 0, 0, 0);
        RST = 1'b0;
        cmp_en = 1'b1;

        // 1: mode 0 does not trigger at 0x0131, mode 1 does
        cyc(3);
        lit(0, "mode0_no_flash", 0, 0, 0);
        ModeSel = 1'b1;
        cyc(1);
        lit(0, "mode1_start", 1, 1, 0);
        tick_once();
        lit(0, "mode1_off", 0, 1, 1);
        tick_once();
        lit(0, "mode1_on_again", 1, 1, 1);

        // 2: Stopped forces idle; TV out of mode-1 range keeps it idle
        Stopped = 1'b1;
        cyc(1);
        lit(0, "stopped", 0, 0, 1);
        Stopped = 1'b0; MSB = 8'd80; LSB = 8'd0;
        cyc(3);
        lit(0, "out_of_range", 0, 0, 1);

        // 3: mode 0 continuous flashing across a TV change
        ModeSel = 1'b0; MSB = 8'd90;
        cyc(1);
        lit(0, "mode0_start", 1, 1, 0);
        tick_once();
        tick_once();
        MSB = 8'd95;
        cyc(1);
        tick_once();
        lit(0, "no_restart", 0, 1, 2);

        // 4: five flashes at Rate=2 then HOLD, ack, new episode
        MSB = 8'd0;
        cyc(1);
        Rate = 3'd2; MSB = 8'd90;
        cyc(1);
        for (int i = 1; i <= 20; i++) begin
            tick_once();
            cyc(1);
            if (i == 2) lit(0, "rate2_first_off", 0, 1, 1);
        end
        lit(0, "hold", 1, 1, 5);
        tick_once();
        tick_once();
        lit(0, "hold_steady", 1, 1, 5);
        Ack = 1'b1;
        cyc(1);
        lit(0, "acked", 0, 0, 5);
        Ack = 1'b0;
        tick_once();
        cyc(2);
        lit(0, "acked_stays", 0, 0, 5);
        MSB = 8'd0;
        cyc(1);
        MSB = 8'd90;
        cyc(1);
        lit(0, "new_episode", 1, 1, 0);

        // 5: Rate=0 acts as 1; reset mid-flash with a tick; tick on cond rise ignored
        Rate = 3'd0;
        tick_once();
        lit(0, "rate0_off", 0, 1, 1);
        tick_once();
        RST = 1'b1; TICK = 1'b1;
        cyc(1);
        RST = 1'b0;
        lit(0, "reset_mid_flash", 0, 0, 0);
        Rate = 3'd2;
        cyc(1);
        TICK = 1'b0;
        lit(0, "tick_on_rise", 1, 1, 0);
        tick_once();
        lit(0, "rate2_one_tick", 1, 1, 0);
        tick_once();
        lit(0, "rate2_two_ticks", 0, 1, 1);
        tick_once();
        Rate = 3'd1;
        tick_once();
        lit(0, "rate_lowered", 1, 1, 1);

        // 6: mode switch to a non-matching mode; out-of-range ModeSel
        ModeSel = 1'b1;
        cyc(1);
        lit(0, "mode_switch_idle", 0, 0, 1);
        lit(1, "modesel3_off", 0, 0, 0);
        ModeSel3 = 2'd2;
        cyc(1);
        lit(1, "mode2_start", 1, 1, 0);
        tick_once();
        ModeSel3 = 2'd3;
        cyc(1);
        lit(1, "modesel3_idle", 0, 0, 1);
        cyc(2);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
